// File: rtl/cmp_stream_unit.sv
// Two-stage valid/ready compare unit: EQ/GT/LT codes plus running MAX/MIN trackers.
// Stage 1 registers the operands; stage 2 evaluates, updates trackers and holds the result.
module cmp_stream_unit #(
  parameter int DATA_WIDTH = 16,
  parameter int OUT_WIDTH  = 3
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic [2:0]            ALU_FUNC,
  input  logic                  SIGNED_EN,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  input  logic                  OUT_READY,
  output logic [OUT_WIDTH-1:0]  CMP_OUT,
  output logic [DATA_WIDTH-1:0] CMP_DATA,
  output logic                  CMP_Flag,
  output logic                  CMP_ERR
);

  localparam logic [2:0] FN_NOP = 3'b000;
  localparam logic [2:0] FN_EQ  = 3'b001;
  localparam logic [2:0] FN_GT  = 3'b010;
  localparam logic [2:0] FN_LT  = 3'b011;
  localparam logic [2:0] FN_MAX = 3'b100;
  localparam logic [2:0] FN_MIN = 3'b101;
  localparam logic [2:0] FN_CLR = 3'b110;

  logic                  s1_valid_reg;
  logic [DATA_WIDTH-1:0] a_s1_reg, b_s1_reg;
  logic [2:0]            func_s1_reg;
  logic                  signed_s1_reg;

  logic                  flag_reg, err_reg;
  logic [OUT_WIDTH-1:0]  out_reg;
  logic [DATA_WIDTH-1:0] data_reg;
  logic [DATA_WIDTH-1:0] max_reg, min_reg;
  logic                  max_valid_reg, min_valid_reg;

  logic                  s1_en, s2_en;
  logic                  err_next, max_valid_next, min_valid_next;
  logic [OUT_WIDTH-1:0]  out_next;
  logic [DATA_WIDTH-1:0] data_next, max_next, min_next;

  // Flipping the MSB maps two's-complement order onto unsigned order.
  function automatic logic gt_f(input logic [DATA_WIDTH-1:0] x, input logic [DATA_WIDTH-1:0] y,
                                input logic s);
    return {x[DATA_WIDTH-1] ^ s, x[DATA_WIDTH-2:0]} > {y[DATA_WIDTH-1] ^ s, y[DATA_WIDTH-2:0]};
  endfunction

  assign s2_en    = !flag_reg || OUT_READY;
  assign s1_en    = !s1_valid_reg || s2_en;
  assign IN_READY = s1_en;

  assign CMP_Flag = flag_reg;
  assign CMP_OUT  = out_reg;
  assign CMP_DATA = data_reg;
  assign CMP_ERR  = err_reg;

  always_comb begin
    out_next       = '0;
    data_next      = '0;
    err_next       = 1'b0;
    max_next       = max_reg;
    max_valid_next = max_valid_reg;
    min_next       = min_reg;
    min_valid_next = min_valid_reg;
    case (func_s1_reg)
      FN_NOP: ;
      FN_EQ:  if (a_s1_reg == b_s1_reg) out_next = OUT_WIDTH'(1);
      FN_GT:  if (gt_f(a_s1_reg, b_s1_reg, signed_s1_reg)) out_next = OUT_WIDTH'(2);
      FN_LT:  if (gt_f(b_s1_reg, a_s1_reg, signed_s1_reg)) out_next = OUT_WIDTH'(3);
      FN_MAX: begin
        if (!max_valid_reg || gt_f(a_s1_reg, max_reg, signed_s1_reg)) begin
          max_next = a_s1_reg;
          out_next = OUT_WIDTH'(1);
        end
        max_valid_next = 1'b1;
        data_next      = max_next;
      end
      FN_MIN: begin
        if (!min_valid_reg || gt_f(min_reg, a_s1_reg, signed_s1_reg)) begin
          min_next = a_s1_reg;
          out_next = OUT_WIDTH'(1);
        end
        min_valid_next = 1'b1;
        data_next      = min_next;
      end
      FN_CLR: begin
        max_next       = '0;
        max_valid_next = 1'b0;
        min_next       = '0;
        min_valid_next = 1'b0;
      end
      default: err_next = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      s1_valid_reg  <= 1'b0;
      a_s1_reg      <= '0;
      b_s1_reg      <= '0;
      func_s1_reg   <= FN_NOP;
      signed_s1_reg <= 1'b0;
    end else if (s1_en) begin
      s1_valid_reg <= IN_VALID;
      if (IN_VALID) begin
        a_s1_reg      <= A;
        b_s1_reg      <= B;
        func_s1_reg   <= ALU_FUNC;
        signed_s1_reg <= SIGNED_EN;
      end
    end
  end

  // Trackers move only when stage 2 captures a valid op, so a stall cannot repeat an update.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      flag_reg      <= 1'b0;
      out_reg       <= '0;
      data_reg      <= '0;
      err_reg       <= 1'b0;
      max_reg       <= '0;
      max_valid_reg <= 1'b0;
      min_reg       <= '0;
      min_valid_reg <= 1'b0;
    end else if (s2_en) begin
      flag_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        out_reg       <= out_next;
        data_reg      <= data_next;
        err_reg       <= err_next;
        max_reg       <= max_next;
        max_valid_reg <= max_valid_next;
        min_reg       <= min_next;
        min_valid_reg <= min_valid_next;
      end else begin
        out_reg  <= '0;
        data_reg <= '0;
        err_reg  <= 1'b0;
      end
    end
  end

endmodule

// File: doc/cmp_stream_unit.md
Name: cmp_stream_unit

Overview:
Parametrised successor to the team's registered comparator. Adds signed/unsigned compare, running MAX/MIN tracking and a 2-stage valid/ready pipeline with full backpressure. Sits between the operand register file and the ALU result mux, and feeds the result/flag path of the system controller.

Parameters:
DATA_WIDTH, 16, operand width (>=2)
OUT_WIDTH, 3, compare-code output width (>=2)

Ports:
CLK  input  1  system clock, all state on rising edge
RST  input  1  asynchronous active-low reset
A  input  DATA_WIDTH  operand A
B  input  DATA_WIDTH  operand B
ALU_FUNC  input  3  operation select
SIGNED_EN  input  1  1 = two's-complement compare, 0 = unsigned
IN_VALID  input  1  operands/function valid
IN_READY  output  1  block accepts a transfer this cycle
OUT_READY  input  1  downstream accepts the result
CMP_OUT  output  OUT_WIDTH  compare code
CMP_DATA  output  DATA_WIDTH  tracked MAX/MIN value
CMP_Flag  output  1  result valid
CMP_ERR  output  1  reserved function code, qualified by CMP_Flag

Behaviour:
- Reset (async, RST=0): both stage valids 0; CMP_OUT, CMP_DATA, CMP_Flag, CMP_ERR = 0; max/min trackers cleared, track-valid bits 0. IN_READY = 1 once RST is released.
- Transfers: input transfer when IN_VALID & IN_READY; output transfer when CMP_Flag & OUT_READY.
- Pipeline: stage 1 registers A, B, ALU_FUNC, SIGNED_EN. Stage 2 computes and registers the outputs.
- Advance enables: s2_en = !CMP_Flag | OUT_READY; s1_en = !s1_valid | s2_en; IN_READY = s1_en (combinational, no skid buffer).
- Latency: 2 cycles from input transfer to CMP_Flag=1 with no stall. Throughput is 1 per cycle when OUT_READY=1.
- Stall: while CMP_Flag=1 and OUT_READY=0, all outputs hold stable and stage 1 holds. IN_READY=0 if stage 1 is also full.
- Comparison: signed when SIGNED_EN=1, else unsigned, for GT/LT/MAX/MIN. EQ is sign-independent.
- Function codes, applied at stage-2 capture:
  - 000 NOP: CMP_OUT=0, CMP_DATA=0.
  - 001 EQ: CMP_OUT=1 if A==B, else 0.
  - 010 GT: CMP_OUT=2 if A>B, else 0.
  - 011 LT: CMP_OUT=3 if A<B, else 0.
  - 100 MAX: if max-track invalid or A>max, max<=A. Set max-valid. CMP_DATA=new max. CMP_OUT=1 if max changed, else 0. B is ignored.
  - 101 MIN: mirror of MAX using A<min and the min tracker.
  - 110 CLR: clear both trackers and track-valid bits. CMP_OUT=0, CMP_DATA=0.
  - 111 reserved: CMP_OUT=0, CMP_ERR=1; trackers unchanged.
- CMP_ERR=0 for all other codes.
- Every accepted op, including NOP/CLR/reserved, produces exactly one result with CMP_Flag=1.
- CMP_DATA=0 for NOP/EQ/GT/LT/CLR/reserved.
- Compare codes are zero-extended to OUT_WIDTH.
- Trackers update only on stage-2 capture, so back-to-back MAX ops see each predecessor's update (in-order, no hazard).
- Stalls never cause a duplicate or dropped tracker update.
- SIGNED_EN applies per transaction. Trackers store raw bits; mixing signedness between MAX ops is legal and uses the current op's mode.
- Reset mid-operation discards in-flight transactions; no result is emitted after RST release until a new input transfer.
- IN_VALID/operands are don't-care when IN_VALID=0.

Test Plan:
- Reset: assert RST=0 mid-stream with both stages full -> CMP_Flag=0, CMP_OUT=0, CMP_DATA=0 immediately (async); IN_READY=1 after release; no stale result emitted.
- Latency/throughput: 3 back-to-back ops, OUT_READY=1: EQ A=B=0x1234, GT A=0x0005 B=0x0003, LT A=0x0002 B=0x0009 -> CMP_Flag=1 on cycles 2,3,4 with CMP_OUT=1,2,3.
- Signedness: GT A=0xFFFF B=0x0001 -> CMP_OUT=2 with SIGNED_EN=0 and CMP_OUT=0 with SIGNED_EN=1. LT on the same operands with SIGNED_EN=1 -> CMP_OUT=3.
- Tracking: MAX A=0x0010, 0x0008, 0x0020 -> CMP_DATA=0x0010,0x0010,0x0020, CMP_OUT=1,0,1. Then CLR, then MAX A=0x0001 -> CMP_DATA=0x0001, CMP_OUT=1.
- Backpressure: OUT_READY=0 for 4 cycles with IN_VALID=1 -> IN_READY=0 after 2 accepts; outputs stable. On release, results appear in order with none lost or duplicated; MAX tracker updated exactly once per op.
- Reserved code 111 -> CMP_Flag=1, CMP_ERR=1, CMP_OUT=0. A following MIN op -> CMP_ERR=0, trackers unaffected by the reserved op.
